mb_dp_bram: RTL and testbench

MB_DP_BRAM -- requirements
Module: mb_dp_bram

---
 rtl/mb_dp_bram_if.sv | 27 ++
 rtl/mb_dp_bram.sv | 201 ++++++++++++++++++++
 tb/tb_mb_dp_bram.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mb_dp_bram_if.sv
// Request/response bundle for one port of the banked dual-port RAM.
// The master drives requests and receives responses; the slave is the memory.
interface mb_dp_bram_if #(
  parameter int unsigned W  = 128,
  parameter int unsigned AW = 10
);
  localparam int unsigned NB = W / 8;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_din;
  logic [NB-1:0] req_be;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_din, req_be,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_din, req_be,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mb_dp_bram.sv
// Dual-port RAM built from NBANKS single-port banks, word-interleaved by the low
// address bits, with round-robin arbitration when both ports hit the same bank.
module mb_dp_bram #(
  parameter int unsigned W           = 128,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned NBANKS      = 4,
  parameter int unsigned USE_BYTE_EN = 1,
  parameter int unsigned OUT_REG     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mb_dp_bram_if.slave  a,
  mb_dp_bram_if.slave  b,
  output logic [31:0]  conflict_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned BW   = $clog2(NBANKS);
  localparam int unsigned BSW  = (BW > 0) ? BW : 1;
  localparam int unsigned RW   = AW - BW;
  localparam int unsigned RSW  = (RW > 0) ? RW : 1;
  localparam int unsigned ROWS = DEPTH / NBANKS;
  localparam int unsigned NB   = W / 8;

  logic [1:0]     req_valid;
  logic [1:0]     req_we;
  logic [AW-1:0]  req_addr [2];
  logic [W-1:0]   req_din  [2];
  logic [NB-1:0]  req_be   [2];
  logic [BSW-1:0] req_bank [2];
  logic [RSW-1:0] req_row  [2];

  logic [1:0]     req_ready_c;
  logic [1:0]     fire_c;
  logic           conflict_c;

  logic           rr_q;
  logic [31:0]    cnt_q;

  logic [W-1:0]   bank_rdata [NBANKS];
  logic [1:0]     rsp_valid_w;
  logic [W-1:0]   rsp_data_w [2];

  assign req_valid   = {b.req_valid, a.req_valid};
  assign req_we      = {b.req_we, a.req_we};
  assign req_addr[0] = a.req_addr;
  assign req_addr[1] = b.req_addr;
  assign req_din[0]  = a.req_din;
  assign req_din[1]  = b.req_din;
  assign req_be[0]   = a.req_be;
  assign req_be[1]   = b.req_be;

  // Low address bits pick the bank, the rest pick the row inside it.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_bank[p] = '0;
      req_row[p]  = '0;
      if (BW > 0) begin
        req_bank[p] = BSW'(req_addr[p]);
      end
      if (RW > 0) begin
        req_row[p] = RSW'(req_addr[p] >> BW);
      end
    end
  end

  // Arbitration: the loser of a same-bank collision is stalled; identical addresses still collide.
  always_comb begin
    conflict_c     = req_valid[0] & req_valid[1] & (req_bank[0] == req_bank[1]);
    req_ready_c[0] = rst_n & ~(conflict_c & rr_q);
    req_ready_c[1] = rst_n & ~(conflict_c & ~rr_q);
    fire_c         = req_valid & req_ready_c;
  end

  assign a.req_ready = req_ready_c[0];
  assign b.req_ready = req_ready_c[1];

  // Round-robin pointer hands priority to the losing side after each collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= 1'b0;
      cnt_q <= '0;
    end else if (conflict_c) begin
      rr_q <= ~rr_q;
      if (cnt_q != 32'hFFFF_FFFF) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign conflict_cnt = cnt_q;

  for (genvar k = 0; k < NBANKS; k++) begin : g_bank
    logic [W-1:0]   mem [ROWS];
    logic [W-1:0]   rdata_q;
    logic           hit_a_c;
    logic           hit_b_c;
    logic           en_c;
    logic           we_c;
    logic [RSW-1:0] row_c;
    logic [W-1:0]   wdata_c;
    logic [NB-1:0]  wbe_c;

    // At most one port can reach a bank per cycle, so a simple mux suffices.
    always_comb begin
      hit_a_c = fire_c[0] & (req_bank[0] == BSW'(k));
      hit_b_c = fire_c[1] & (req_bank[1] == BSW'(k));
      en_c    = hit_a_c | hit_b_c;
      we_c    = hit_b_c ? req_we[1]   : req_we[0];
      row_c   = hit_b_c ? req_row[1]  : req_row[0];
      wdata_c = hit_b_c ? req_din[1]  : req_din[0];
      wbe_c   = hit_b_c ? req_be[1]   : req_be[0];
      if (USE_BYTE_EN == 0) begin
        wbe_c = '1;
      end
    end

    always_ff @(posedge clk) begin
      if (en_c) begin
        if (we_c) begin
          for (int i = 0; i < NB; i++) begin
            if (wbe_c[i]) begin
              mem[row_c][8*i +: 8] <= wdata_c[8*i +: 8];
            end
          end
        end else begin
          rdata_q <= mem[row_c];
        end
      end
    end

    assign bank_rdata[k] = rdata_q;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic           s0_vld_q;
    logic [BSW-1:0] s0_bank_q;
    logic [W-1:0]   s0_data_c;
    logic           rsp_vld_q;
    logic [W-1:0]   rsp_data_q;

    // Remember which bank holds this port's read so its data can be steered out next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s0_vld_q  <= 1'b0;
        s0_bank_q <= '0;
      end else begin
        s0_vld_q <= fire_c[p] & ~req_we[p];
        if (fire_c[p]) begin
          s0_bank_q <= req_bank[p];
        end
      end
    end

    assign s0_data_c = bank_rdata[s0_bank_q];

    if (OUT_REG != 0) begin : g_oreg
      logic         s1_vld_q;
      logic [W-1:0] s1_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld_q   <= 1'b0;
          s1_data_q  <= '0;
          rsp_vld_q  <= 1'b0;
          rsp_data_q <= '0;
        end else begin
          s1_vld_q  <= s0_vld_q;
          rsp_vld_q <= s1_vld_q;
          if (s0_vld_q) begin
            s1_data_q <= s0_data_c;
          end
          if (s1_vld_q) begin
            rsp_data_q <= s1_data_q;
          end
        end
      end
    end else begin : g_noreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_vld_q  <= 1'b0;
          rsp_data_q <= '0;
        end else begin
          rsp_vld_q <= s0_vld_q;
          if (s0_vld_q) begin
            rsp_data_q <= s0_data_c;
          end
        end
      end
    end

    assign rsp_valid_w[p] = rsp_vld_q;
    assign rsp_data_w[p]  = rsp_data_q;
  end

  assign a.rsp_valid = rsp_valid_w[0];
  assign a.rsp_data  = rsp_data_w[0];
  assign b.rsp_valid = rsp_valid_w[1];
  assign b.rsp_data  = rsp_data_w[1];

endmodule

// File: tb/tb_mb_dp_bram.sv
// Bench for mb_dp_bram: a word-array/queue model checked every cycle, plus directed scenarios
// with literal expectations for latency, ordering, arbitration, byte enables and reset.
module tb_mb_dp_bram;

  localparam int unsigned W       = 128;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned NBANKS  = 4;
  localparam int unsigned OUT_REG = 1;
  localparam int unsigned AW      = 10;
  localparam int unsigned NB      = W / 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] conflict_cnt;

  always #5 clk = ~clk;

  mb_dp_bram_if #(.W(W), .AW(AW)) a_if ();
  mb_dp_bram_if #(.W(W), .AW(AW)) b_if ();

  mb_dp_bram #(
    .W(W), .DEPTH(DEPTH), .NBANKS(NBANKS), .USE_BYTE_EN(1), .OUT_REG(OUT_REG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a_if),
    .b            (b_if),
    .conflict_cnt (conflict_cnt)
  );

  typedef struct {
    longint       due;
    logic [W-1:0] data;
  } exp_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  longint       edge_n  = 0;

  logic [W-1:0] mdl_mem [DEPTH];
  int           mdl_rr;
  logic [31:0]  mdl_cnt;
  exp_t         q [2][$];
  logic [W-1:0] last_data [2];

  // Observations of the DUT used by the directed literal checks.
  int           rsp_cnt  [2];
  longint       rsp_edge [2];
  longint       acc_edge [2];
  logic [W-1:0] rsp_last [2];
  int           run      [2];
  logic         prev_v   [2];
  bit           grant_hist [$];

  logic         pv [2], pwe [2], prdy [2], prv [2], erdy [2];
  logic [AW-1:0] paddr [2];
  logic [W-1:0] pdin [2], prd [2];
  logic [NB-1:0] pbe [2];
  logic         conf;

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model and compare process: inputs are stable here and apply at the next rising edge.
  always @(negedge clk) begin
    pv[0] = a_if.req_valid;  pv[1] = b_if.req_valid;
    pwe[0] = a_if.req_we;    pwe[1] = b_if.req_we;
    paddr[0] = a_if.req_addr; paddr[1] = b_if.req_addr;
    pdin[0] = a_if.req_din;  pdin[1] = b_if.req_din;
    pbe[0] = a_if.req_be;    pbe[1] = b_if.req_be;
    prdy[0] = a_if.req_ready; prdy[1] = b_if.req_ready;
    prv[0] = a_if.rsp_valid; prv[1] = b_if.rsp_valid;
    prd[0] = a_if.rsp_data;  prd[1] = b_if.rsp_data;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rst_ready_%0d", p), W'(prdy[p]), '0);
        chk($sformatf("rst_rsp_valid_%0d", p), W'(prv[p]), '0);
        chk($sformatf("rst_rsp_data_%0d", p), prd[p], '0);
        q[p].delete();
        last_data[p] = '0;
        prev_v[p] = 1'b0;
      end
      chk("rst_conflict_cnt", W'(conflict_cnt), '0);
      mdl_rr = 0;
      mdl_cnt = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (q[p].size() != 0 && q[p][0].due == edge_n) begin
          chk($sformatf("rsp_valid_%0d", p), W'(prv[p]), W'(1));
          chk($sformatf("rsp_data_%0d", p), prd[p], q[p][0].data);
          last_data[p] = q[p][0].data;
          void'(q[p].pop_front());
        end else begin
          chk($sformatf("rsp_idle_valid_%0d", p), W'(prv[p]), '0);
          chk($sformatf("rsp_hold_data_%0d", p), prd[p], last_data[p]);
        end
        if (prv[p]) begin
          rsp_cnt[p]++;
          rsp_edge[p] = edge_n;
          rsp_last[p] = prd[p];
          run[p] = prev_v[p] ? run[p] + 1 : 1;
        end
        prev_v[p] = prv[p];
      end
      chk("conflict_cnt", W'(conflict_cnt), W'(mdl_cnt));
      conf = pv[0] && pv[1] && ((paddr[0] % NBANKS) == (paddr[1] % NBANKS));
      erdy[0] = !(conf && mdl_rr == 1);
      erdy[1] = !(conf && mdl_rr == 0);
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("req_ready_%0d", p), W'(prdy[p]), W'(erdy[p]));
        if (pv[p] && prdy[p] && !pwe[p]) acc_edge[p] = edge_n + 1;
      end
      for (int p = 0; p < 2; p++) begin
        if (pv[p] && erdy[p] && !pwe[p]) begin
          exp_t e;
          e.due  = edge_n + 2 + OUT_REG;
          e.data = mdl_mem[paddr[p]];
          q[p].push_back(e);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (pv[p] && erdy[p] && pwe[p]) begin
          for (int i = 0; i < NB; i++) begin
            if (pbe[p][i]) mdl_mem[paddr[p]][8*i +: 8] = pdin[p][8*i +: 8];
          end
        end
      end
      if (conf) begin
        grant_hist.push_back(prdy[1]);
        mdl_rr = 1 - mdl_rr;
        if (mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
      end
    end
  end

  // Present one request on a port and hold it until it transfers (bounded).
  task automatic do_req(input int p, input bit we, input logic [AW-1:0] addr,
                        input logic [W-1:0] din, input logic [NB-1:0] be);
    int  budget;
    bit  f;
    budget = 0;
    if (p == 0) begin
      a_if.req_valid = 1'b1; a_if.req_we = we; a_if.req_addr = addr;
      a_if.req_din = din; a_if.req_be = be;
    end else begin
      b_if.req_valid = 1'b1; b_if.req_we = we; b_if.req_addr = addr;
      b_if.req_din = din; b_if.req_be = be;
    end
    forever begin
      @(negedge clk);
      f = (p == 0) ? a_if.req_ready : b_if.req_ready;
      @(posedge clk);
      #1;
      if (f) break;
      budget++;
      if (budget > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL req_timeout_%0d: actual=not granted required=granted addr=%0d", p, addr);
        break;
      end
    end
    if (p == 0) a_if.req_valid = 1'b0;
    else        b_if.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input int p, input logic [AW-1:0] addr, input logic [W-1:0] exp,
                          input string name);
    do_req(p, 1'b0, addr, '0, '0);
    idle(4);
    chk(name, rsp_last[p], exp);
  endtask

  initial begin
    logic [W-1:0] pat;
    int           c0, c1;

    rst_n = 1'b0;
    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0; a_if.req_din = '0; a_if.req_be = '0;
    b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0; b_if.req_din = '0; b_if.req_be = '0;
    for (int p = 0; p < 2; p++) begin
      rsp_cnt[p] = 0; rsp_edge[p] = 0; acc_edge[p] = 0; rsp_last[p] = '0; run[p] = 0; prev_v[p] = 1'b0;
    end
    idle(3);
    chk("reset_cnt_literal", W'(conflict_cnt), W'(0));
    rst_n = 1'b1;
    idle(2);

    // Single write then read: two-cycle latency after accept with the output register.
    do_req(0, 1'b1, 10'd5, {4{32'hDEADBEEF}}, '1);
    do_req(0, 1'b0, 10'd5, '0, '0);
    idle(5);
    chk("s1_data", rsp_last[0], {4{32'hDEADBEEF}});
    chk("s1_latency", W'(rsp_edge[0] - acc_edge[0]), W'(2));
    chk("s1_rsp_count", W'(rsp_cnt[0]), W'(1));

    // A fills 0..63, B streams the reads back-to-back.
    for (int i = 0; i < 64; i++) do_req(0, 1'b1, AW'(i), W'(i + 1), '1);
    c1 = rsp_cnt[1];
    for (int i = 0; i < 64; i++) do_req(1, 1'b0, AW'(i), '0, '0);
    idle(5);
    chk("s2_rsp_count", W'(rsp_cnt[1] - c1), W'(64));
    chk("s2_consecutive", W'(run[1]), W'(64));
    chk("s2_last_data", rsp_last[1], W'(64));
    chk("s2_conflicts", W'(conflict_cnt), W'(0));

    // Byte-enabled partial write over a byte-index pattern.
    for (int i = 0; i < NB; i++) pat[8*i +: 8] = 8'(i);
    do_req(0, 1'b1, 10'd100, pat, '1);
    do_req(1, 1'b1, 10'd100, '1, 16'h000F);
    rd_check(0, 10'd100, 128'h0f0e0d0c_0b0a0908_07060504_ffffffff, "be_partial");

    // Both ports hammer bank 0: grants alternate A, B, A, B.
    grant_hist.delete();
    c0 = rsp_cnt[0];
    c1 = rsp_cnt[1];
    fork
      begin
        do_req(0, 1'b0, 10'd0, '0, '0);
        do_req(0, 1'b0, 10'd0, '0, '0);
        do_req(0, 1'b0, 10'd0, '0, '0);
      end
      begin
        do_req(1, 1'b0, 10'd4, '0, '0);
        do_req(1, 1'b0, 10'd4, '0, '0);
      end
    join
    idle(5);
    chk("s3_conflicts", W'(conflict_cnt), W'(4));
    chk("s3_grants", W'(grant_hist.size()), W'(4));
    if (grant_hist.size() == 4) begin
      chk("s3_grant0", W'(grant_hist[0]), W'(0));
      chk("s3_grant1", W'(grant_hist[1]), W'(1));
      chk("s3_grant2", W'(grant_hist[2]), W'(0));
      chk("s3_grant3", W'(grant_hist[3]), W'(1));
    end
    chk("s3_rsp_a", W'(rsp_cnt[0] - c0), W'(3));
    chk("s3_rsp_b", W'(rsp_cnt[1] - c1), W'(2));
    chk("s3_data_a", rsp_last[0], W'(1));
    chk("s3_data_b", rsp_last[1], W'(5));

    // Reset lands while a read is in flight: it must never come out.
    c0 = rsp_cnt[0];
    do_req(0, 1'b0, 10'd10, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(6);
    chk("s4_no_rsp", W'(rsp_cnt[0] - c0), W'(0));
    chk("s4_cnt_cleared", W'(conflict_cnt), W'(0));

    // Boundary addresses written on B, read on A.
    do_req(1, 1'b1, 10'd0,    128'hA000, '1);
    do_req(1, 1'b1, 10'd511,  128'hA1FF, '1);
    do_req(1, 1'b1, 10'd1023, 128'hA3FF, '1);
    rd_check(0, 10'd0,    128'hA000, "s5_addr0");
    rd_check(0, 10'd511,  128'hA1FF, "s5_addr511");
    rd_check(0, 10'd1023, 128'hA3FF, "s5_addr1023");
    // 1023 shares bank 3 with address 3 but not bank 2 with address 2.
    fork
      do_req(0, 1'b0, 10'd1023, '0, '0);
      do_req(1, 1'b0, 10'd3, '0, '0);
    join
    fork
      do_req(0, 1'b0, 10'd1023, '0, '0);
      do_req(1, 1'b0, 10'd2, '0, '0);
    join
    idle(5);
    chk("s5_bank3_conflict", W'(conflict_cnt), W'(1));
    chk("s5_data_b", rsp_last[1], W'(3));
    chk("drain", W'(q[0].size() + q[1].size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
